// File: rtl/usb2_vreq_sched.sv
// rtl/usb2_vreq_sched.sv - EP0 vendor-request queue with one-hot command dispatch,
// per-command completion timeout and sticky overflow/timeout error reporting.
module usb2_vreq_sched #(
  parameter int DEPTH   = 4,
  parameter int TIMEOUT = 4096
) (
  input  logic        phy_clk,
  input  logic        reset,
  input  logic        vend_req_act,
  input  logic [7:0]  vend_req_request,
  input  logic [15:0] vend_req_val,
  input  logic        flush,
  output logic [3:0]  cmd_valid,
  output logic [7:0]  cmd_request,
  output logic [15:0] cmd_val,
  input  logic [3:0]  cmd_done,
  output logic        busy,
  output logic        err_overflow,
  output logic        err_timeout,
  output logic [7:0]  drop_cnt,
  input  logic        err_clear
);

  localparam int          AW       = $clog2(DEPTH);
  localparam logic [AW:0] FULL_CNT = (AW+1)'(DEPTH);
  localparam logic [15:0] TMO_LAST = 16'(TIMEOUT - 1);

  typedef enum logic [1:0] {IDLE, ISSUE, WAIT} state_t;

  state_t        state_q, state_d;
  logic          act_q;
  logic [AW-1:0] wr_ptr_q, wr_ptr_d, rd_ptr_q, rd_ptr_d;
  logic [AW:0]   cnt_q, cnt_d;
  logic [23:0]   mem_q [DEPTH];
  logic [1:0]    tgt_q, tgt_d;
  logic [7:0]    req_q, req_d;
  logic [15:0]   val_q, val_d;
  logic [3:0]    valid_q, valid_d;
  logic [15:0]   tmo_q, tmo_d;
  logic          ovf_q, ovf_d, terr_q, terr_d;
  logic [7:0]    drop_q, drop_d;

  logic          req_edge, full, pop, push, drop, tmo_hit;

  assign req_edge = vend_req_act & ~act_q;
  assign full     = (cnt_q == FULL_CNT);
  // A pop in the same cycle frees the slot, so a full queue still accepts.
  assign push     = req_edge & ~flush & (~full | pop);
  assign drop     = req_edge & ~flush & full & ~pop;

  always_comb begin
    state_d = state_q;
    tgt_d   = tgt_q;
    req_d   = req_q;
    val_d   = val_q;
    valid_d = valid_q;
    tmo_d   = tmo_q;
    pop     = 1'b0;
    tmo_hit = 1'b0;
    if (flush) begin
      state_d = IDLE;
      valid_d = 4'b0000;
      tmo_d   = 16'd0;
    end else begin
      case (state_q)
        IDLE: begin
          if (cnt_q != '0) begin
            pop     = 1'b1;
            req_d   = mem_q[rd_ptr_q][23:16];
            val_d   = mem_q[rd_ptr_q][15:0];
            tgt_d   = mem_q[rd_ptr_q][23:22];
            tmo_d   = 16'd0;
            state_d = ISSUE;
          end
        end
        ISSUE: begin
          valid_d = 4'b0001 << tgt_q;
          state_d = WAIT;
        end
        WAIT: begin
          if (cmd_done[tgt_q]) begin
            valid_d = 4'b0000;
            state_d = IDLE;
          end else if (tmo_q == TMO_LAST) begin
            valid_d = 4'b0000;
            tmo_hit = 1'b1;
            state_d = IDLE;
          end else begin
            tmo_d = tmo_q + 16'd1;
          end
        end
        default: begin
          valid_d = 4'b0000;
          state_d = IDLE;
        end
      endcase
    end
  end

  always_comb begin
    wr_ptr_d = wr_ptr_q;
    rd_ptr_d = rd_ptr_q;
    cnt_d    = cnt_q;
    if (flush) begin
      wr_ptr_d = '0;
      rd_ptr_d = '0;
      cnt_d    = '0;
    end else begin
      if (push) wr_ptr_d = wr_ptr_q + AW'(1);
      if (pop)  rd_ptr_d = rd_ptr_q + AW'(1);
      if (push && !pop)      cnt_d = cnt_q + (AW+1)'(1);
      else if (pop && !push) cnt_d = cnt_q - (AW+1)'(1);
    end
  end

  // Clearing wins over a same-cycle error so software never loses a clear.
  always_comb begin
    ovf_d  = err_clear ? 1'b0 : (ovf_q | drop);
    terr_d = err_clear ? 1'b0 : (terr_q | tmo_hit);
    drop_d = drop_q;
    if (err_clear)                   drop_d = 8'd0;
    else if (drop && drop_q != 8'hFF) drop_d = drop_q + 8'd1;
  end

  always_ff @(posedge phy_clk or posedge reset) begin
    if (reset) begin
      state_q  <= IDLE;
      act_q    <= 1'b0;
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      cnt_q    <= '0;
      tgt_q    <= 2'd0;
      req_q    <= 8'd0;
      val_q    <= 16'd0;
      valid_q  <= 4'b0000;
      tmo_q    <= 16'd0;
      ovf_q    <= 1'b0;
      terr_q   <= 1'b0;
      drop_q   <= 8'd0;
    end else begin
      state_q  <= state_d;
      act_q    <= vend_req_act;
      wr_ptr_q <= wr_ptr_d;
      rd_ptr_q <= rd_ptr_d;
      cnt_q    <= cnt_d;
      tgt_q    <= tgt_d;
      req_q    <= req_d;
      val_q    <= val_d;
      valid_q  <= valid_d;
      tmo_q    <= tmo_d;
      ovf_q    <= ovf_d;
      terr_q   <= terr_d;
      drop_q   <= drop_d;
    end
  end

  always_ff @(posedge phy_clk) begin
    if (push) mem_q[wr_ptr_q] <= {vend_req_request, vend_req_val};
  end

  assign cmd_valid    = valid_q;
  assign cmd_request  = req_q;
  assign cmd_val      = val_q;
  assign busy         = (cnt_q != '0) | (state_q != IDLE);
  assign err_overflow = ovf_q;
  assign err_timeout  = terr_q;
  assign drop_cnt     = drop_q;

endmodule
